// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin owner of the single memory bus shared by icache and dcache,
// with a turnaround gap between owners and a sticky starvation flag.
module mem_bus_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int TURNAROUND     = 1,
  parameter int MAX_HOLD       = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      icache_busreq,
  input  logic                      dcache_busreq,
  input  logic                      icache_busidle,
  input  logic                      dcache_busidle,
  output logic                      icache_busgrant,
  output logic                      dcache_busgrant,
  input  logic                      i_reqcyc,
  input  logic                      d_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] i_req,
  input  logic [BUS_DATA_WIDTH-1:0] d_req,
  input  logic [BUS_TAG_WIDTH-1:0]  i_reqtag,
  input  logic [BUS_TAG_WIDTH-1:0]  d_reqtag,
  input  logic                      i_respack,
  input  logic                      d_respack,
  output logic                      i_reqack,
  output logic                      d_reqack,
  output logic                      i_respcyc,
  output logic                      d_respcyc,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_respack,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  output logic [1:0]                owner,
  output logic                      starve_err
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, TURN} state_e;
  state_e        state_q, state_d;
  logic          last_d_q, last_d_d;
  logic [3:0]    turn_q, turn_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          starve_q, starve_d;
  logic          pick_i, pick_d, rel_i, rel_d, arb, other_wait;
  // Tie goes to whichever side was not served last.
  assign pick_i     = icache_busreq & (~dcache_busreq | last_d_q);
  assign pick_d     = dcache_busreq & (~icache_busreq | ~last_d_q);
  assign rel_i      = ~icache_busreq & icache_busidle;
  assign rel_d      = ~dcache_busreq & dcache_busidle;
  assign arb        = state_q == IDLE || (state_q == TURN && turn_q == 4'd0);
  assign other_wait = (state_q == GNT_I && dcache_busreq) || (state_q == GNT_D && icache_busreq);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      last_d_q <= 1'b1;
      turn_q   <= '0;
      hold_q   <= '0;
      starve_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      turn_q   <= turn_d;
      hold_q   <= hold_d;
      starve_q <= starve_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    turn_d   = turn_q;
    if (arb) state_d = pick_i ? GNT_I : pick_d ? GNT_D : IDLE;
    else if (state_q == TURN) turn_d = turn_q - 4'd1;
    else if ((state_q == GNT_I && rel_i) || (state_q == GNT_D && rel_d)) begin
      state_d  = TURN;
      last_d_d = state_q == GNT_D;
      turn_d   = 4'(TURNAROUND - 1);
    end
  end
  // The grant is never revoked on starvation; the counter only raises the flag.
  always_comb begin
    hold_d = '0;
    if ((state_q == GNT_I || state_q == GNT_D) && state_d == state_q)
      hold_d = (other_wait && hold_q != HW'(MAX_HOLD)) ? hold_q + 1'b1 : hold_q;
    starve_d = starve_q | (hold_d == HW'(MAX_HOLD));
  end
  always_comb begin
    icache_busgrant = state_q == GNT_I;
    dcache_busgrant = state_q == GNT_D;
    owner           = {dcache_busgrant, icache_busgrant};
    starve_err      = starve_q;
    bus_reqcyc      = icache_busgrant ? i_reqcyc  : dcache_busgrant ? d_reqcyc  : 1'b0;
    bus_req         = icache_busgrant ? i_req     : dcache_busgrant ? d_req     : '0;
    bus_reqtag      = icache_busgrant ? i_reqtag  : dcache_busgrant ? d_reqtag  : '0;
    bus_respack     = icache_busgrant ? i_respack : dcache_busgrant ? d_respack : 1'b0;
    i_reqack        = icache_busgrant & bus_reqack;
    d_reqack        = dcache_busgrant & bus_reqack;
    i_respcyc       = icache_busgrant & bus_respcyc;
    d_respcyc       = dcache_busgrant & bus_respcyc;
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios plus random traffic, checked every cycle
// against a cycle-count based ownership model.
module tb_mem_bus_arbiter;
  localparam int DW = 64, TW = 13, TA = 1, MH = 8;
  logic clk = 1'b0, reset = 1'b0, run = 1'b0;
  logic icache_busreq, dcache_busreq, icache_busidle, dcache_busidle;
  logic icache_busgrant, dcache_busgrant;
  logic i_reqcyc, d_reqcyc, i_respack, d_respack, i_reqack, d_reqack, i_respcyc, d_respcyc;
  logic [DW-1:0] i_req, d_req, bus_req;
  logic [TW-1:0] i_reqtag, d_reqtag, bus_reqtag;
  logic bus_reqcyc, bus_respack, bus_reqack, bus_respcyc, starve_err;
  logic [1:0] owner;
  int checks = 0, errors = 0;
  int m_own = 0, m_last = 2, m_free = 0, m_wait = 0, cyc = 0;
  bit m_starve = 1'b0;

  mem_bus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .TURNAROUND(TA), .MAX_HOLD(MH)) dut (
    .clk(clk), .reset(reset),
    .icache_busreq(icache_busreq), .dcache_busreq(dcache_busreq),
    .icache_busidle(icache_busidle), .dcache_busidle(dcache_busidle),
    .icache_busgrant(icache_busgrant), .dcache_busgrant(dcache_busgrant),
    .i_reqcyc(i_reqcyc), .d_reqcyc(d_reqcyc), .i_req(i_req), .d_req(d_req),
    .i_reqtag(i_reqtag), .d_reqtag(d_reqtag), .i_respack(i_respack), .d_respack(d_respack),
    .i_reqack(i_reqack), .d_reqack(d_reqack), .i_respcyc(i_respcyc), .d_respcyc(d_respcyc),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_respack(bus_respack),
    .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .owner(owner), .starve_err(starve_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit rq(int who);
    return who == 1 ? icache_busreq : dcache_busreq;
  endfunction

  function automatic bit idl(int who);
    return who == 1 ? icache_busidle : dcache_busidle;
  endfunction

  // Model: owner 0/1/2; after a release the bus is free again TA edges later.
  always @(posedge clk or negedge reset) begin
    int nw;
    if (!reset) begin
      m_own <= 0; m_last <= 2; m_free <= 0; m_wait <= 0; m_starve <= 1'b0;
    end else begin
      if (m_own != 0) begin
        if (!rq(m_own) && idl(m_own)) begin
          m_own <= 0; m_last <= m_own; m_free <= cyc + TA; m_wait <= 0;
        end else begin
          nw = m_wait + (rq(3 - m_own) ? 1 : 0);
          if (nw > MH) nw = MH;
          m_wait <= nw;
          if (nw == MH) m_starve <= 1'b1;
        end
      end else if (cyc >= m_free)
        m_own <= (icache_busreq && dcache_busreq) ? 3 - m_last : icache_busreq ? 1 : dcache_busreq ? 2 : 0;
      cyc <= cyc + 1;
    end
  end

  always @(negedge clk) if (run) begin
    chk("m_igrant", icache_busgrant, m_own == 1);
    chk("m_dgrant", dcache_busgrant, m_own == 2);
    chk("m_owner", owner, m_own);
    chk("m_starve", starve_err, m_starve);
    chk("m_reqcyc", bus_reqcyc, m_own == 1 ? i_reqcyc : m_own == 2 ? d_reqcyc : 1'b0);
    chk("m_req", bus_req, m_own == 1 ? i_req : m_own == 2 ? d_req : '0);
    chk("m_reqtag", bus_reqtag, m_own == 1 ? i_reqtag : m_own == 2 ? d_reqtag : '0);
    chk("m_respack", bus_respack, m_own == 1 ? i_respack : m_own == 2 ? d_respack : 1'b0);
    chk("m_acks", {i_reqack, d_reqack, i_respcyc, d_respcyc},
        {m_own == 1 && bus_reqack, m_own == 2 && bus_reqack, m_own == 1 && bus_respcyc, m_own == 2 && bus_respcyc});
  end

  initial begin
    {icache_busreq, dcache_busreq, i_reqcyc, d_reqcyc, i_respack, d_respack, bus_reqack, bus_respcyc} = '0;
    {icache_busidle, dcache_busidle} = 2'b11;
    i_req = '0; d_req = '0; i_reqtag = '0; d_reqtag = '0;
    #12 reset = 1'b1;
    run = 1'b1;
    step();
    chk("rst_owner", owner, 2'b00);
    chk("rst_starve", starve_err, 1'b0);
    icache_busreq = 1'b1; i_reqcyc = 1'b1; i_req = 64'h80;
    #1 chk("lat_nogrant", icache_busgrant, 1'b0);
    step();
    chk("t1_igrant", icache_busgrant, 1'b1);
    chk("t1_owner", owner, 2'b01);
    chk("t1_reqcyc", bus_reqcyc, 1'b1);
    chk("t1_req", bus_req, 64'h80);
    icache_busreq = 1'b0; i_reqcyc = 1'b0;
    step();
    chk("t1_rel_owner", owner, 2'b00);
    #2 reset = 1'b0;
    #1 reset = 1'b1;
    {icache_busreq, dcache_busreq, icache_busidle, dcache_busidle} = 4'b1100;
    step();
    chk("t2_tie_i", owner, 2'b01);
    icache_busreq = 1'b0; icache_busidle = 1'b1;
    step();
    chk("t2_gap", {icache_busgrant, dcache_busgrant}, 2'b00);
    step();
    chk("t2_dgrant", dcache_busgrant, 1'b1);
    chk("t2_owner", owner, 2'b10);
    dcache_busreq = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_hold", dcache_busgrant, 1'b1);
    end
    bus_respcyc = 1'b1;
    #1 chk("t5_resp_d", {i_respcyc, d_respcyc}, 2'b01);
    bus_respcyc = 1'b0;
    dcache_busidle = 1'b1;
    step();
    chk("t3_release", dcache_busgrant, 1'b0);
    bus_respcyc = 1'b1;
    #1 chk("t5_resp_none", {i_respcyc, d_respcyc}, 2'b00);
    bus_respcyc = 1'b0;
    dcache_busreq = 1'b1; dcache_busidle = 1'b0;
    step();
    chk("t4_dgrant", dcache_busgrant, 1'b1);
    icache_busreq = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("t4_starve", starve_err, k >= 8);
      chk("t4_dkeep", dcache_busgrant, 1'b1);
    end
    dcache_busreq = 1'b0; dcache_busidle = 1'b1;
    step();
    chk("t4_rel", {owner, starve_err}, 3'b001);
    step();
    chk("t4_igrant", {owner, starve_err}, 3'b011);
    i_reqcyc = 1'b1;
    #1 chk("t6_pre_reqcyc", bus_reqcyc, 1'b1);
    #1 reset = 1'b0;
    #1 chk("t6_async", {icache_busgrant, dcache_busgrant, owner, bus_reqcyc, starve_err}, 6'b0);
    reset = 1'b1;
    dcache_busreq = 1'b1;
    step();
    chk("t6_prio_i", owner, 2'b01);
    for (int n = 0; n < 3000; n++) begin
      step();
      icache_busreq = 1'($urandom_range(0, 1));
      dcache_busreq = 1'($urandom_range(0, 1));
      icache_busidle = 1'($urandom_range(0, 1));
      dcache_busidle = 1'($urandom_range(0, 1));
      {i_reqcyc, d_reqcyc, i_respack, d_respack, bus_reqack, bus_respcyc} = 6'($urandom);
      i_req = {$urandom, $urandom}; d_req = {$urandom, $urandom};
      i_reqtag = TW'($urandom); d_reqtag = TW'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        #2 reset = 1'b0;
        #1 reset = 1'b1;
      end
    end
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external memory bus between the instruction cache and the data cache.
- Implements the busreq/busidle/busgrant handshake that each cache already exposes.
- Runs a round-robin ownership FSM with a configurable turnaround gap.
- Muxes the request-side bus signals from the current owner and routes handshake responses back to that owner only.

Parameters:
- BUS_DATA_WIDTH, 64, width of bus_req/bus_resp.
- BUS_TAG_WIDTH, 13, width of request/response tags.
- TURNAROUND, 1, idle cycles between release and next grant (legal range 1..15).
- MAX_HOLD, 1024, grant-hold cycles with the other side waiting before starvation is flagged.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- icache_busreq / dcache_busreq  in  1  requester wants the bus.
- icache_busidle / dcache_busidle  in  1  requester has no outstanding bus transaction.
- icache_busgrant / dcache_busgrant  out  1  registered grant.
- i_reqcyc, d_reqcyc  in  1  per-cache bus_reqcyc.
- i_req, d_req  in  BUS_DATA_WIDTH  per-cache bus_req.
- i_reqtag, d_reqtag  in  BUS_TAG_WIDTH  per-cache bus_reqtag.
- i_respack, d_respack  in  1  per-cache bus_respack.
- i_reqack, d_reqack  out  1  routed bus_reqack.
- i_respcyc, d_respcyc  out  1  routed bus_respcyc.
- bus_reqcyc  out  1  to memory.
- bus_req  out  BUS_DATA_WIDTH  to memory.
- bus_reqtag  out  BUS_TAG_WIDTH  to memory.
- bus_respack  out  1  to memory.
- bus_reqack  in  1  from memory.
- bus_respcyc  in  1  from memory.
- bus_resp, bus_resptag are broadcast to both caches externally and are not ports here.
- owner  out  2  00 none, 01 icache, 10 dcache.
- starve_err  out  1  sticky starvation flag.

Behaviour:
- Reset (reset low, async): state IDLE, both grants 0, owner 00, last_served = D, hold counter 0, starve_err 0, turnaround counter 0.
  - Consequence: icache wins the first tie after reset.
- States:
  - IDLE
  - GNT_I
  - GNT_D
  - TURN
- IDLE:
  - Only one busreq high: enter that GNT_x; grant and owner asserted next edge (1-cycle request-to-grant latency).
  - Both high: grant the side != last_served.
  - Neither high: stay in IDLE.
- GNT_x:
  - Grant held high.
  - Release condition: owner busreq == 0 AND busidle == 1, sampled at the same edge.
  - On release at edge N, at edge N+1: grant = 0, owner = 00, last_served = x, state TURN with counter = TURNAROUND-1.
  - busidle high while busreq is still high does not release.
  - busreq dropping while busidle is low does not release (transaction still in flight).
- TURN:
  - Counts down; all grants low.
  - At count 0 the FSM evaluates requests exactly as in IDLE during that same cycle, so the next grant appears TURNAROUND+1 cycles after release.
- Muxing (combinational on registered owner):
  - owner 01: bus_reqcyc/req/reqtag/respack = i_*; i_reqack = bus_reqack; i_respcyc = bus_respcyc; d_* outputs 0.
  - owner 10: symmetric, using d_* inputs and outputs.
  - owner 00: bus_reqcyc = 0, bus_respack = 0, bus_req/reqtag = 0; all routed outputs 0.
  - bus_respcyc arriving with owner 00 is dropped.
- Starvation:
  - Hold counter increments each cycle in GNT_x while the non-owner's busreq is high.
  - Saturates at MAX_HOLD; clears on entering IDLE or TURN.
  - When the counter reaches MAX_HOLD, starve_err sets and stays set until reset.
  - The grant is never revoked, because mid-transaction revocation corrupts the bus.
- A grant never changes while the owner's busidle is 0.
- Both grants are never high in the same cycle.
- Reset asserted mid-transaction: grants drop immediately (async) and bus_reqcyc goes 0 the same instant.

Test Plan:
- icache_busreq=1 alone at cycle 2 -> icache_busgrant=1 and owner=01 at cycle 3; i_reqcyc=1, i_req=0x80 appear on bus_reqcyc/bus_req in the same cycle.
- Both busreq high from reset release -> icache granted first; after icache releases (busreq=0, busidle=1), with TURNAROUND=1, dcache_busgrant rises exactly 2 cycles after the release edge.
- dcache owner with busreq=0 but busidle=0 for 5 cycles -> grant held all 5 cycles; release occurs only on the first cycle with busidle=1.
- MAX_HOLD=8: dcache holds while icache_busreq is high for 10 cycles -> starve_err rises on the 8th cycle, dcache grant is unaffected, and starve_err stays 1 after release.
- bus_respcyc=1 with owner=10 -> d_respcyc=1, i_respcyc=0; bus_respcyc=1 with owner=00 -> both routed outputs 0.
- Reset driven low mid-grant between clock edges -> both grants, owner and bus_reqcyc go 0 immediately; after reset release, IDLE with icache priority.
